sobel_edge_filter: RTL and testbench

Consumes the 3×3 pixel window produced each pixel strobe by the upstream line-buffer sliding window and computes a Sobel gradient magnitude and thresholded edge flag for the window centre. It tracks frame coordinates of the centre pixel, forces border outputs to zero, and emits one result per frame pixel through a 3-stage pipeline. It sits directly downstream of the line buffer and shares its `EN` strobe.

---
 rtl/sobel_edge_filter.sv | 231 +++++++++++++++++++++++
 tb/tb_sobel_edge_filter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_filter.sv
// rtl/sobel_edge_filter.sv - Sobel gradient magnitude and edge flag on a 3x3 sliding window
// Tracks the centre-pixel frame coordinates, zeroes border results, 3-stage pipeline.
module sobel_edge_filter #(
   parameter int unsigned WIDTH   = 640,
   parameter int unsigned HEIGHT  = 480,
   parameter int unsigned PIXEL_W = 8,
   parameter int unsigned LAG     = 2*WIDTH-1,
   localparam int unsigned CW     = $clog2(WIDTH),
   localparam int unsigned RW     = $clog2(HEIGHT),
   localparam int unsigned FW     = $clog2(LAG+1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   EN,
   input  logic                   sof,
   input  logic [9*PIXEL_W-1:0]   window,
   input  logic [PIXEL_W-1:0]     thresh,
   output logic                   out_valid,
   output logic [PIXEL_W-1:0]     magnitude,
   output logic                   edge_flag,
   output logic [CW-1:0]          out_col,
   output logic [RW-1:0]          out_row,
   output logic                   out_eof
);

   localparam int unsigned SW = PIXEL_W + 2;
   localparam int unsigned DW = PIXEL_W + 3;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  col_q, col_d;
   logic [RW-1:0]  row_q, row_d;
   logic           fill_armed_q, fill_armed_d;
   logic [FW-1:0]  fill_cnt_q, fill_cnt_d;

   logic           fill_expire;
   logic           emit;
   logic [CW-1:0]  cur_col;
   logic [RW-1:0]  cur_row;
   logic           last_col;
   logic           last_row;
   logic           cur_border;

   // The fill counter decides which strobe carries centre (0,0); a fresh sof always reloads it.
   always_comb begin
      fill_expire  = EN && fill_armed_q && (fill_cnt_q == '0);
      emit         = EN && (fill_expire || (state_q == RUN));
      cur_col      = fill_expire ? '0 : col_q;
      cur_row      = fill_expire ? '0 : row_q;
      last_col     = (cur_col == CW'(WIDTH-1));
      last_row     = (cur_row == RW'(HEIGHT-1));
      cur_border   = (cur_col == '0) || last_col || (cur_row == '0) || last_row;

      fill_armed_d = fill_armed_q;
      fill_cnt_d   = fill_cnt_q;
      if (EN && sof) begin
         fill_armed_d = 1'b1;
         fill_cnt_d   = FW'(LAG-1);
      end else if (fill_expire) begin
         fill_armed_d = 1'b0;
      end else if (EN && fill_armed_q) begin
         fill_cnt_d   = fill_cnt_q - 1'b1;
      end

      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      if (emit) begin
         if (last_col && last_row) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
         end else begin
            state_d = RUN;
            if (last_col) begin
               col_d = '0;
               row_d = cur_row + 1'b1;
            end else begin
               col_d = cur_col + 1'b1;
               row_d = cur_row;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         fill_armed_q <= 1'b0;
         fill_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         fill_armed_q <= fill_armed_d;
         fill_cnt_q   <= fill_cnt_d;
      end
   end

   // Stage 1: capture the window and centre bookkeeping.
   logic                  s1_valid_q;
   logic [9*PIXEL_W-1:0]  s1_taps_q;
   logic [CW-1:0]         s1_col_q;
   logic [RW-1:0]         s1_row_q;
   logic                  s1_border_q;
   logic                  s1_eof_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_taps_q   <= '0;
         s1_col_q    <= '0;
         s1_row_q    <= '0;
         s1_border_q <= 1'b0;
         s1_eof_q    <= 1'b0;
      end else begin
         s1_valid_q <= emit;
         if (emit) begin
            s1_taps_q   <= window;
            s1_col_q    <= cur_col;
            s1_row_q    <= cur_row;
            s1_border_q <= cur_border;
            s1_eof_q    <= last_col && last_row;
         end
      end
   end

   // Stage 2: gradients as two's-complement differences of weighted column/row sums.
   logic [PIXEL_W-1:0] w [9];
   logic [SW-1:0]      gx_pos, gx_neg, gy_pos, gy_neg;
   logic [DW-1:0]      gx_d, gy_d;

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         w[i] = s1_taps_q[i*PIXEL_W +: PIXEL_W];
      end
      gx_pos = {2'b00, w[2]} + {1'b0, w[5], 1'b0} + {2'b00, w[8]};
      gx_neg = {2'b00, w[0]} + {1'b0, w[3], 1'b0} + {2'b00, w[6]};
      gy_pos = {2'b00, w[6]} + {1'b0, w[7], 1'b0} + {2'b00, w[8]};
      gy_neg = {2'b00, w[0]} + {1'b0, w[1], 1'b0} + {2'b00, w[2]};
      gx_d   = {1'b0, gx_pos} - {1'b0, gx_neg};
      gy_d   = {1'b0, gy_pos} - {1'b0, gy_neg};
   end

   logic               s2_valid_q;
   logic [DW-1:0]      s2_gx_q, s2_gy_q;
   logic [CW-1:0]      s2_col_q;
   logic [RW-1:0]      s2_row_q;
   logic               s2_border_q;
   logic               s2_eof_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s2_valid_q  <= 1'b0;
         s2_gx_q     <= '0;
         s2_gy_q     <= '0;
         s2_col_q    <= '0;
         s2_row_q    <= '0;
         s2_border_q <= 1'b0;
         s2_eof_q    <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_gx_q     <= gx_d;
            s2_gy_q     <= gy_d;
            s2_col_q    <= s1_col_q;
            s2_row_q    <= s1_row_q;
            s2_border_q <= s1_border_q;
            s2_eof_q    <= s1_eof_q;
         end
      end
   end

   // Stage 3: |Gx|+|Gy|, saturate, threshold; border centres are forced to zero.
   logic [DW-1:0]       abs_gx, abs_gy;
   logic [PIXEL_W+3:0]  mag_sum;
   logic [PIXEL_W-1:0]  mag_d;
   logic                edge_d;

   always_comb begin
      abs_gx  = s2_gx_q[DW-1] ? (~s2_gx_q + 1'b1) : s2_gx_q;
      abs_gy  = s2_gy_q[DW-1] ? (~s2_gy_q + 1'b1) : s2_gy_q;
      mag_sum = {1'b0, abs_gx} + {1'b0, abs_gy};
      mag_d   = (|mag_sum[PIXEL_W+3:PIXEL_W]) ? {PIXEL_W{1'b1}} : mag_sum[PIXEL_W-1:0];
      edge_d  = (mag_d >= thresh);
      if (s2_border_q) begin
         mag_d  = '0;
         edge_d = 1'b0;
      end
   end

   logic                out_valid_q;
   logic [PIXEL_W-1:0]  magnitude_q;
   logic                edge_q;
   logic [CW-1:0]       out_col_q;
   logic [RW-1:0]       out_row_q;
   logic                out_eof_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         magnitude_q <= '0;
         edge_q      <= 1'b0;
         out_col_q   <= '0;
         out_row_q   <= '0;
         out_eof_q   <= 1'b0;
      end else begin
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            magnitude_q <= mag_d;
            edge_q      <= edge_d;
            out_col_q   <= s2_col_q;
            out_row_q   <= s2_row_q;
            out_eof_q   <= s2_eof_q;
         end else begin
            out_eof_q   <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign magnitude = magnitude_q;
   assign edge_flag = edge_q;
   assign out_col   = out_col_q;
   assign out_row   = out_row_q;
   assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb/tb_sobel_edge_filter.sv - scoreboard bench for sobel_edge_filter on an 8x4 frame
module tb_sobel_edge_filter;

   localparam int W   = 8;
   localparam int H   = 4;
   localparam int LAG = 2*W-1;
   localparam int NP  = W*H;

   localparam int P_FLAT  = 0;
   localparam int P_HRAMP = 1;
   localparam int P_STEP  = 2;
   localparam int P_DIAG  = 3;
   localparam int P_SPOT  = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        EN = 1'b0;
   logic        sof = 1'b0;
   logic [71:0] window = '0;
   logic [7:0]  thresh = '0;
   logic        out_valid;
   logic [7:0]  magnitude;
   logic        edge_flag;
   logic [2:0]  out_col;
   logic [1:0]  out_row;
   logic        out_eof;

   sobel_edge_filter #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(8)) dut (
      .clock(clock), .reset(reset), .EN(EN), .sof(sof), .window(window), .thresh(thresh),
      .out_valid(out_valid), .magnitude(magnitude), .edge_flag(edge_flag),
      .out_col(out_col), .out_row(out_row), .out_eof(out_eof)
   );

   always #5 clock = ~clock;

   longint cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int     col;
      int     row;
      int     mag;
      int     edg;
      int     eof;
      longint cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic int pix(input int pat, input int x, input int y);
      int cx, cy;
      cx = (x < 0) ? 0 : ((x > W-1) ? W-1 : x);
      cy = (y < 0) ? 0 : ((y > H-1) ? H-1 : y);
      case (pat)
         P_FLAT:  return 50;
         P_HRAMP: return 10*cx;
         P_STEP:  return (cx < 4) ? 0 : 100;
         P_DIAG:  return 10*cx + 20*cy;
         default: return (cx == 3 && cy == 1) ? 64 : 0;
      endcase
   endfunction

   function automatic logic [71:0] mk_window(input int pat, input int x, input int y);
      logic [71:0] wv;
      wv = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            wv[(r*3+c)*8 +: 8] = 8'(pix(pat, x+c-1, y+r-1));
      return wv;
   endfunction

   function automatic logic [71:0] rnd_window();
      logic [71:0] wv;
      wv = '0;
      for (int i = 0; i < 9; i++) wv[i*8 +: 8] = 8'($urandom);
      return wv;
   endfunction

   // Hand-derived magnitudes for each directed pattern.
   function automatic int exp_mag(input int pat, input int x, input int y);
      if (x == 0 || x == W-1 || y == 0 || y == H-1) return 0;
      case (pat)
         P_FLAT:  return 0;
         P_HRAMP: return 80;
         P_STEP:  return (x == 3 || x == 4) ? 255 : 0;
         P_DIAG:  return 240;
         default: return ((y == 1 && (x == 2 || x == 4)) || (y == 2 && x >= 2 && x <= 4)) ? 128 : 0;
      endcase
   endfunction

   always @(negedge clock) begin
      if (out_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result actual col=%0d row=%0d mag=%0d required no out_valid at cycle %0d",
                     out_col, out_row, magnitude, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (int'(out_col) != e.col || int'(out_row) != e.row || int'(magnitude) != e.mag ||
                int'(edge_flag) != e.edg || int'(out_eof) != e.eof || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL result actual col=%0d row=%0d mag=%0d edge=%0d eof=%0d cyc=%0d required col=%0d row=%0d mag=%0d edge=%0d eof=%0d cyc=%0d",
                        out_col, out_row, magnitude, edge_flag, out_eof, cyc,
                        e.col, e.row, e.mag, e.edg, e.eof, e.cyc);
            end
         end
      end
   end

   task automatic check_zero(input string name);
      n_checks++;
      if ({out_valid, magnitude, edge_flag, out_col, out_row, out_eof} != '0) begin
         n_fail++;
         $display("FAIL %s actual valid=%0d mag=%0d edge=%0d col=%0d row=%0d eof=%0d required all 0",
                  name, out_valid, magnitude, edge_flag, out_col, out_row, out_eof);
      end
   endtask

   // Strobe k carries centre pixel k-base-LAG; gap cycles drive sof=1 with EN=0, which must be ignored.
   task automatic run_stream(input int pat, input int th, input int nframes, input int gap,
                             input int base, input int stop_at);
      int total, p, lp, x, y, m;
      exp_t e;
      thresh = 8'(th);
      total = base + LAG + nframes*NP + 4;
      for (int k = 0; k < total; k++) begin
         if (stop_at >= 0 && k == stop_at) return;
         @(negedge clock);
         EN  = 1'b1;
         sof = (k == 0) || (k >= base && ((k-base) % NP) == 0 && ((k-base) / NP) < nframes);
         p = k - base - LAG;
         if (p >= 0 && p < nframes*NP) begin
            lp = p % NP;
            x = lp % W;
            y = lp / W;
            window = mk_window(pat, x, y);
            m = exp_mag(pat, x, y);
            e.col = x;
            e.row = y;
            e.mag = m;
            e.edg = (x != 0 && x != W-1 && y != 0 && y != H-1 && m >= th) ? 1 : 0;
            e.eof = (x == W-1 && y == H-1) ? 1 : 0;
            e.cyc = cyc + 3;
            sb.push_back(e);
         end else begin
            window = rnd_window();
         end
         for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            EN = 1'b0;
            sof = 1'b1;
            window = rnd_window();
         end
      end
      @(negedge clock);
      EN = 1'b0;
      sof = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(negedge clock);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain actual %0d results outstanding required 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual time limit reached required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      check_zero("reset_state");
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_zero("idle_after_reset");

      run_stream(P_FLAT, 10, 1, 0, 0, -1);   drain("flat");
      run_stream(P_FLAT, 0, 1, 0, 0, -1);    drain("flat_thresh0");
      run_stream(P_HRAMP, 100, 1, 0, 0, -1); drain("hramp");
      run_stream(P_STEP, 200, 1, 0, 0, -1);  drain("vstep");
      run_stream(P_STEP, 200, 1, 2, 0, -1);  drain("vstep_gaps");
      run_stream(P_DIAG, 241, 1, 0, 0, -1);  drain("diag");
      run_stream(P_SPOT, 128, 1, 0, 0, -1);  drain("spot");
      run_stream(P_HRAMP, 80, 2, 0, 0, -1);  drain("back_to_back");
      run_stream(P_STEP, 200, 1, 0, 5, -1);  drain("early_sof");

      run_stream(P_FLAT, 10, 1, 0, 0, 25);
      @(negedge clock);
      #1;
      reset = 1'b1;
      EN = 1'b0;
      sof = 1'b0;
      sb.delete();
      @(negedge clock);
      check_zero("mid_stream_reset");
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         EN = 1'b1;
         sof = 1'b0;
         window = rnd_window();
         @(negedge clock);
         EN = 1'b0;
         sof = 1'b1;
      end
      @(negedge clock);
      sof = 1'b0;
      repeat (5) @(negedge clock);
      check_zero("no_output_without_sof");
      run_stream(P_HRAMP, 100, 1, 0, 0, -1); drain("after_reset");

      repeat (5) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
